// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
// ----------------
// This block shares one single-port block RAM data port between two requesters:
//   port 0 : CPU load/store. It has fixed priority.
//   port 1 : peripheral DMA engine. A starvation guard protects it.
//
// Grant behaviour
//   - A grant is decided combinationally in the cycle the request is made.
//   - The grantee's command is muxed onto the RAM port in that same cycle.
//   - Read data and its valid strobe come back exactly one cycle later.
//   - A refused requester keeps its command held and retries.
//     Nothing is queued inside the arbiter.
//
// Optional feature (compile-time macro ARB_LOCK_EN)
//   - Adds input lock0.
//   - While lock0 is high and port 0 was granted in the previous cycle,
//     the starvation force for port 1 is suppressed.
//   - This keeps a CPU read-modify-write sequence atomic.
//
// Ports
//   clk, rst                  clock, asynchronous active-low reset
//   lock0                     (ARB_LOCK_EN only) port 0 lock request
//   reqN/weN/beN/addrN/wdataN requester N command
//   gntN                      requester N granted this cycle
//   rvalidN/rdataN            requester N read return
//                             (rdataN is 0 while rvalidN is low)
//   mem_we/mem_be/mem_addr/mem_wdata  RAM command
//   mem_rdata                 RAM read data, valid one cycle after the address
//   starve_cnt                number of consecutive cycles port 1 has been refused
module ram_port_arbiter #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic            clk,
  input  logic            rst,
`ifdef ARB_LOCK_EN
  input  logic            lock0,
`endif
  input  logic            req0,
  input  logic            we0,
  input  logic [DW/8-1:0] be0,
  input  logic [AW-1:0]   addr0,
  input  logic [DW-1:0]   wdata0,
  output logic            gnt0,
  output logic            rvalid0,
  output logic [DW-1:0]   rdata0,
  input  logic            req1,
  input  logic            we1,
  input  logic [DW/8-1:0] be1,
  input  logic [AW-1:0]   addr1,
  input  logic [DW-1:0]   wdata1,
  output logic            gnt1,
  output logic            rvalid1,
  output logic [DW-1:0]   rdata1,
  output logic            mem_we,
  output logic [DW/8-1:0] mem_be,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic [DW-1:0]   mem_rdata,
  output logic [3:0]      starve_cnt
);

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  logic [3:0] starve_cnt_reg;
  logic       rd_tag0_reg;     // a port 0 read was granted last cycle
  logic       rd_tag1_reg;     // a port 1 read was granted last cycle
  logic       lock_hold;
  logic       force1;

`ifdef ARB_LOCK_EN
  logic gnt0_prev_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gnt0_prev_reg <= 1'b0;
    end else begin
      gnt0_prev_reg <= gnt0;
    end
  end

  // The lock only holds once port 0 actually owns the RAM.
  // Raising lock0 cannot steal a cycle that port 1 is being forced into.
  assign lock_hold = lock0 && gnt0_prev_reg;
`else
  assign lock_hold = 1'b0;
`endif

  // Arbitration
  assign force1 = req1 && (starve_cnt_reg >= MAX_WAIT_C) && !lock_hold;
  assign gnt1   = req1 && (!req0 || force1);
  assign gnt0   = req0 && !gnt1;

  // RAM command mux.
  // When nothing is granted, the address and write data stay on
  // port 0's values. The RAM sees no write and no byte enables.
  always_comb begin
    mem_we    = 1'b0;
    mem_be    = '0;
    mem_addr  = addr0;
    mem_wdata = wdata0;
    if (gnt1) begin
      mem_we    = we1;
      mem_be    = be1;
      mem_addr  = addr1;
      mem_wdata = wdata1;
    end else if (gnt0) begin
      mem_we    = we0;
      mem_be    = be0;
    end
  end

  // Read-return tags and the starvation counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_tag0_reg    <= 1'b0;
      rd_tag1_reg    <= 1'b0;
      starve_cnt_reg <= 4'd0;
    end else begin
      rd_tag0_reg <= gnt0 && !we0;
      rd_tag1_reg <= gnt1 && !we1;
      if (!req1 || gnt1) begin
        starve_cnt_reg <= 4'd0;
      end else if (starve_cnt_reg != 4'hF) begin
        starve_cnt_reg <= starve_cnt_reg + 4'd1;
      end
    end
  end

  assign rvalid0    = rd_tag0_reg;
  assign rvalid1    = rd_tag1_reg;
  assign rdata0     = rd_tag0_reg ? mem_rdata : '0;
  assign rdata1     = rd_tag1_reg ? mem_rdata : '0;
  assign starve_cnt = starve_cnt_reg;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed testbench for ram_port_arbiter.
// A small reference model predicts, for every cycle:
//   - the grants,
//   - the RAM command,
//   - the starvation count.
// Each predicted granted read pushes its expected return onto a scoreboard.
// That entry is popped and compared in the following cycle.
module tb_ram_port_arbiter;

  localparam int MAX_WAIT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        lock0;
  logic        req0, we0, req1, we1;
  logic [3:0]  be0, be1;
  logic [31:0] addr0, wdata0, addr1, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1;
  logic [31:0] rdata0, rdata1;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  starve_cnt;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic        port;
    logic [31:0] data;
  } rd_t;

  rd_t         sb[$];
  logic [3:0]  m_cnt;
  logic        m_prev0;
  logic [31:0] ram_addr_q;

  ram_port_arbiter #(.AW(32), .DW(32), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst),
`ifdef ARB_LOCK_EN
    .lock0(lock0),
`endif
    .req0(req0), .we0(we0), .be0(be0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .be1(be1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
    .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .starve_cnt(starve_cnt)
  );

  always #5 clk = ~clk;

  // Contents of the behavioural RAM
  function automatic logic [31:0] ram_val(input logic [31:0] a);
    if (a == 32'h10) return 32'hDEADBEEF;
    return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One bus cycle.
  // Inputs are driven on the falling edge and checked 1 ns later.
  // The model is then advanced to the value it will hold after the next rising edge.
  task automatic step(input string tag,
                      input logic r0, input logic w0, input logic [3:0] b0,
                      input logic [31:0] a0, input logic [31:0] d0,
                      input logic r1, input logic w1, input logic [3:0] b1,
                      input logic [31:0] a1, input logic [31:0] d1);
    logic f1, eg0, eg1, ew;
    logic [3:0] eb;
    logic [31:0] ea, ed;
    rd_t e;
    @(negedge clk);
    req0 = r0; we0 = w0; be0 = b0; addr0 = a0; wdata0 = d0;
    req1 = r1; we1 = w1; be1 = b1; addr1 = a1; wdata1 = d1;
    mem_rdata = ram_val(ram_addr_q);
    #1;
    f1  = r1 && (m_cnt >= 4'(MAX_WAIT)) && !(lock0 && m_prev0);
    eg1 = r1 && (!r0 || f1);
    eg0 = r0 && !eg1;
    ew  = eg1 ? w1 : (eg0 && w0);
    eb  = eg1 ? b1 : (eg0 ? b0 : 4'h0);
    ea  = eg1 ? a1 : a0;
    ed  = eg1 ? d1 : d0;
    chk({tag, ".gnt0"}, 32'(gnt0), 32'(eg0));
    chk({tag, ".gnt1"}, 32'(gnt1), 32'(eg1));
    chk({tag, ".starve_cnt"}, 32'(starve_cnt), 32'(m_cnt));
    chk({tag, ".mem_we"}, 32'(mem_we), 32'(ew));
    chk({tag, ".mem_be"}, 32'(mem_be), 32'(eb));
    chk({tag, ".mem_addr"}, mem_addr, ea);
    chk({tag, ".mem_wdata"}, mem_wdata, ed);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, ".rvalid0"}, 32'(rvalid0), 32'(!e.port));
      chk({tag, ".rvalid1"}, 32'(rvalid1), 32'(e.port));
      chk({tag, ".rdata0"}, rdata0, e.port ? 32'h0 : e.data);
      chk({tag, ".rdata1"}, rdata1, e.port ? e.data : 32'h0);
    end else begin
      chk({tag, ".rvalid0"}, 32'(rvalid0), 32'h0);
      chk({tag, ".rvalid1"}, 32'(rvalid1), 32'h0);
      chk({tag, ".rdata0"}, rdata0, 32'h0);
      chk({tag, ".rdata1"}, rdata1, 32'h0);
    end
    if (eg0 && !w0) sb.push_back('{1'b0, ram_val(a0)});
    if (eg1 && !w1) sb.push_back('{1'b1, ram_val(a1)});
    ram_addr_q = mem_addr;
    if (!r1 || eg1) m_cnt = 4'd0;
    else if (m_cnt != 4'hF) m_cnt = m_cnt + 4'd1;
    m_prev0 = eg0;
  endtask

  task automatic idle(input string tag);
    step(tag, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  initial begin
    // Reset with a port 0 read held: the grant is visible, no return is expected.
    rst = 1'b0; lock0 = 1'b0; mem_rdata = 32'h0; ram_addr_q = 32'h0;
    req0 = 1'b1; we0 = 1'b0; be0 = 4'hF; addr0 = 32'h10; wdata0 = 32'h0;
    req1 = 1'b0; we1 = 1'b0; be1 = 4'h0; addr1 = 32'h0; wdata1 = 32'h0;
    m_cnt = 4'd0; m_prev0 = 1'b0;
    #2;
    chk("rst.gnt0", 32'(gnt0), 32'h1);
    chk("rst.rvalid0", 32'(rvalid0), 32'h0);
    chk("rst.starve_cnt", 32'(starve_cnt), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst.rvalid0_hold", 32'(rvalid0), 32'h0);
    req0 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    idle("post_rst");

    // Port 0 read of 0x10 returns DEADBEEF one cycle later only
    step("p0_rd", 1'b1, 1'b0, 4'hF, 32'h10, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    idle("p0_ret");
    idle("p0_after");

    // Port 1 partial write with no read return
    step("p1_wr", 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b1, 4'b0011, 32'h40, 32'h0000ABCD);
    idle("p1_wr_after");

    // Both ports reading continuously: port 1 is forced every fifth cycle
    for (int i = 0; i < 12; i++)
      step($sformatf("both%0d", i), 1'b1, 1'b0, 4'hF, 32'h100 + 32'(4*i), 32'h0,
           1'b1, 1'b0, 4'hF, 32'h200 + 32'(4*i), 32'h0);
    idle("both_drain");

    // Alternating single-port reads: returns come on consecutive cycles
    step("alt0", 1'b1, 1'b0, 4'hF, 32'h300, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    step("alt1", 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h304, 32'h0);
    step("alt2", 1'b1, 1'b0, 4'hF, 32'h308, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    idle("alt_drain");

    // Port 1 refused twice, then withdraws: the count clears
    for (int i = 0; i < 2; i++)
      step($sformatf("wd%0d", i), 1'b1, 1'b1, 4'hF, 32'h400, 32'h1234, 1'b1, 1'b0, 4'hF, 32'h500, 32'h0);
    step("wd_drop", 1'b1, 1'b1, 4'hF, 32'h400, 32'h1234, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    idle("wd_idle");

    // Reset asserted while a read return is pending: no strobe afterwards
    step("mid_rd", 1'b1, 1'b0, 4'hF, 32'h600, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    req0 = 1'b0;
    rst = 1'b0;
    sb.delete();
    m_cnt = 4'd0; m_prev0 = 1'b0;
    #1;
    chk("mid_rst.rvalid0", 32'(rvalid0), 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    idle("mid_rst_rel");

`ifdef ARB_LOCK_EN
    // With the lock held, port 1 is never forced and the count saturates.
    // It is forced as soon as the lock drops.
    lock0 = 1'b1;
    for (int i = 0; i < 20; i++)
      step($sformatf("lock%0d", i), 1'b1, 1'b0, 4'hF, 32'h700 + 32'(4*i), 32'h0,
           1'b1, 1'b0, 4'hF, 32'h800, 32'h0);
    chk("lock.sat", 32'(starve_cnt), 32'hF);
    lock0 = 1'b0;
    step("unlock", 1'b1, 1'b0, 4'hF, 32'h7F0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h800, 32'h0);
    idle("unlock_drain");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
